// File: rtl/mfm_sector_seek.sv
// Header-search controller: re-arms the MFM sync detector, parses ID fields
// (FE C H R N CRC), checks CRC-16 and reports found / not-found by index count.
module mfm_sector_seek #(
    parameter int          MAX_INDEX  = 2,
    parameter logic [15:0] CRC_PRESET = 16'hCDB4
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [7:0] i_Track,
    input  logic       i_Head,
    input  logic [7:0] i_Sector,
    input  logic       i_Sync,
    input  logic [7:0] i_Byte,
    input  logic       i_ByteValid,
    input  logic       i_Index,
    output logic       o_SyncRearm,
    output logic       o_Busy,
    output logic       o_Found,
    output logic       o_NotFound,
    output logic       o_HdrValid,
    output logic [7:0] o_HdrC,
    output logic [7:0] o_HdrH,
    output logic [7:0] o_HdrR,
    output logic [7:0] o_HdrN,
    output logic [7:0] o_CrcErrs,
    output logic [2:0] o_DbgState
);

    typedef enum logic [2:0] {IDLE, HUNT, MARK, FIELDS, CRC, CHECK, REARM} state_t;

    localparam logic [3:0] IDX_LAST = 4'(MAX_INDEX - 1);

    state_t      state, state_nx;
    logic [7:0]  req_track, req_sector;
    logic        req_head;
    logic [15:0] crc;
    logic [1:0]  fld_idx;
    logic        crc_idx;
    logic [7:0]  fld_c, fld_h, fld_r, fld_n;
    logic [3:0]  idx_cnt;
    logic        idx_prev;

    logic busy, idx_rise, limit_hit, hdr_good, hdr_match;

    // CRC-CCITT (0x1021), MSB first, one whole byte per call.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    always_comb begin
        busy      = (state != IDLE);
        idx_rise  = i_Index & ~idx_prev;
        // The index limit wins over anything CHECK would otherwise report.
        limit_hit = busy && idx_rise && (idx_cnt == IDX_LAST);
        hdr_good  = (state == CHECK) && (crc == 16'h0000) && !limit_hit;
        hdr_match = hdr_good && (fld_c == req_track) && (fld_h == {7'b0, req_head})
                    && (fld_r == req_sector);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (i_Start) state_nx = HUNT;
            HUNT:   if (i_Sync) state_nx = MARK;
            MARK:   if (i_ByteValid) state_nx = (i_Byte == 8'hFE) ? FIELDS : REARM;
            FIELDS: if (i_ByteValid && fld_idx == 2'd3) state_nx = CRC;
            CRC:    if (i_ByteValid && crc_idx) state_nx = CHECK;
            CHECK:  state_nx = hdr_match ? IDLE : REARM;
            REARM:  state_nx = HUNT;
            default: state_nx = IDLE;
        endcase
        if (limit_hit) state_nx = IDLE;
    end

    always_comb begin
        o_SyncRearm = (state == IDLE) || (state == REARM);
        o_Busy      = busy;
        o_Found     = hdr_match;
        o_HdrValid  = hdr_good;
        o_NotFound  = limit_hit;
        o_DbgState  = state;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= IDLE;
            req_track  <= '0;
            req_head   <= 1'b0;
            req_sector <= '0;
            crc        <= '0;
            fld_idx    <= '0;
            crc_idx    <= 1'b0;
            fld_c      <= '0;
            fld_h      <= '0;
            fld_r      <= '0;
            fld_n      <= '0;
            idx_cnt    <= '0;
            idx_prev   <= 1'b0;
            o_HdrC     <= '0;
            o_HdrH     <= '0;
            o_HdrR     <= '0;
            o_HdrN     <= '0;
            o_CrcErrs  <= '0;
        end else begin
            state    <= state_nx;
            idx_prev <= i_Index;
            if (state == IDLE && i_Start) begin
                req_track  <= i_Track;
                req_head   <= i_Head;
                req_sector <= i_Sector;
                o_CrcErrs  <= '0;
                idx_cnt    <= '0;
            end else if (busy && idx_rise) begin
                idx_cnt <= idx_cnt + 4'd1;
            end
            if (state == MARK && i_ByteValid && i_Byte == 8'hFE) begin
                crc     <= crc_byte(CRC_PRESET, 8'hFE);
                fld_idx <= '0;
                crc_idx <= 1'b0;
            end
            if (state == FIELDS && i_ByteValid) begin
                case (fld_idx)
                    2'd0: fld_c <= i_Byte;
                    2'd1: fld_h <= i_Byte;
                    2'd2: fld_r <= i_Byte;
                    default: fld_n <= i_Byte;
                endcase
                crc     <= crc_byte(crc, i_Byte);
                fld_idx <= fld_idx + 2'd1;
            end
            if (state == CRC && i_ByteValid) begin
                crc     <= crc_byte(crc, i_Byte);
                crc_idx <= 1'b1;
            end
            if (state == CHECK && !limit_hit) begin
                if (crc != 16'h0000) begin
                    if (o_CrcErrs != 8'hFF) o_CrcErrs <= o_CrcErrs + 8'd1;
                end else begin
                    o_HdrC <= fld_c;
                    o_HdrH <= fld_h;
                    o_HdrR <= fld_r;
                    o_HdrN <= fld_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfm_sector_seek.sv
// Scoreboarded bench for mfm_sector_seek: directed scenarios plus randomized
// header streams checked against a byte-level CRC/compare model.
module tb_mfm_sector_seek;

    localparam int W = 35;  // {found, not_found, hdr_valid, C, H, R, N}

    logic       i_Clk = 1'b0;
    logic       i_Reset, i_Start, i_Head, i_Sync, i_ByteValid, i_Index;
    logic [7:0] i_Track, i_Sector, i_Byte;
    logic       o_SyncRearm, o_Busy, o_Found, o_NotFound, o_HdrValid;
    logic [7:0] o_HdrC, o_HdrH, o_HdrR, o_HdrN, o_CrcErrs;
    logic [2:0] o_DbgState;

    mfm_sector_seek #(.MAX_INDEX(2), .CRC_PRESET(16'hCDB4)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Track(i_Track),
        .i_Head(i_Head), .i_Sector(i_Sector), .i_Sync(i_Sync), .i_Byte(i_Byte),
        .i_ByteValid(i_ByteValid), .i_Index(i_Index), .o_SyncRearm(o_SyncRearm),
        .o_Busy(o_Busy), .o_Found(o_Found), .o_NotFound(o_NotFound),
        .o_HdrValid(o_HdrValid), .o_HdrC(o_HdrC), .o_HdrH(o_HdrH), .o_HdrR(o_HdrR),
        .o_HdrN(o_HdrN), .o_CrcErrs(o_CrcErrs), .o_DbgState(o_DbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 i_Clk = ~i_Clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rearm_cnt = 0;
    int crc_model = 0;
    logic [7:0] tgt_c, tgt_r;
    logic       tgt_h;
    logic [7:0] hb[0:6];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    logic       pend = 1'b0;
    logic [2:0] pend_kind;
    always @(negedge i_Clk) begin
        if (i_Reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() == 0) check("unexpected_event", {pend_kind, o_HdrC, o_HdrH, o_HdrR, o_HdrN}, 40'h0);
                else check("event", {pend_kind, o_HdrC, o_HdrH, o_HdrR, o_HdrN}, exp_q.pop_front());
            end
            if (o_HdrValid || o_Found || o_NotFound) begin
                if (o_NotFound) begin
                    if (exp_q.size() == 0) check("unexpected_event", {o_Found, o_NotFound, o_HdrValid, 32'h0}, 40'h0);
                    else check("event", {o_Found, o_NotFound, o_HdrValid, 32'h0}, exp_q.pop_front());
                end else begin
                    pend_kind = {o_Found, o_NotFound, o_HdrValid};
                    pend = 1'b1;
                end
            end
            if (o_SyncRearm && o_Busy) rearm_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_crc(input logic [7:0] b[0:6], input int len);
        logic [15:0] r;
        logic [7:0]  s;
        r = 16'hFFFF;
        for (int k = 0; k < len + 3; k++) begin
            s = (k < 3) ? 8'hA1 : b[k-3];
            for (int i = 7; i >= 0; i--)
                r = {r[14:0], 1'b0} ^ ((r[15] ^ s[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    task automatic make_hdr(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r,
                            input logic [7:0] n);
        logic [15:0] k;
        hb[0] = 8'hFE; hb[1] = c; hb[2] = h; hb[3] = r; hb[4] = n; hb[5] = 0; hb[6] = 0;
        k = model_crc(hb, 5);
        hb[5] = k[15:8];
        hb[6] = k[7:0];
    endtask

    // Predicts the DUT's reaction to a complete FE-led header in hb; returns found.
    function automatic logic expect_hdr();
        logic match;
        if (model_crc(hb, 7) != 16'h0000) begin
            if (crc_model < 255) crc_model++;
            return 1'b0;
        end
        match = (hb[1] == tgt_c) && (hb[2] == {7'b0, tgt_h}) && (hb[3] == tgt_r);
        exp_q.push_back({match, 1'b0, 1'b1, hb[1], hb[2], hb[3], hb[4]});
        return match;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_Clk); #1;
    endtask

    task automatic do_start(input logic [7:0] c, input logic h, input logic [7:0] r);
        tick();
        i_Track = c; i_Head = h; i_Sector = r; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        tgt_c = c; tgt_h = h; tgt_r = r; crc_model = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic idx_end);
        tick();
        i_Byte = b; i_ByteValid = 1'b1;
        tick();
        i_ByteValid = 1'b0;
        i_Index = idx_end;
        repeat (gap) tick();
    endtask

    task automatic send_hdr(input int len, input int gap_max, input logic idx_last);
        tick();
        i_Sync = 1'b1;
        for (int i = 0; i < len; i++)
            send_byte(hb[i], (i == len - 1) ? 0 : $urandom_range(0, gap_max),
                      (i == len - 1) ? idx_last : 1'b0);
        i_Sync = 1'b0;
        repeat (3) tick();
        i_Index = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_Busy && n < 200) begin tick(); n++; end
        if (o_Busy) check(name, 40'd1, 40'd0);
    endtask

    task automatic idx_edge();
        tick(); i_Index = 1'b1;
        repeat (2) tick(); i_Index = 1'b0;
        repeat (2) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic f;
        i_Reset = 1'b1; i_Start = 0; i_Track = 0; i_Head = 0; i_Sector = 0;
        i_Sync = 0; i_Byte = 0; i_ByteValid = 0; i_Index = 0;
        tgt_c = 0; tgt_h = 0; tgt_r = 0;
        #3;
        check("reset_outputs", {o_SyncRearm, o_Busy, o_Found, o_NotFound, o_HdrValid, o_CrcErrs, o_HdrN},
              {1'b1, 4'b0, 8'h00, 8'h00});
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;

        // 1: literal header, pulse one cycle after last strobe
        do_start(8'h00, 1'b0, 8'h01);
        hb[0] = 8'hFE; hb[1] = 8'h00; hb[2] = 8'h00; hb[3] = 8'h01;
        hb[4] = 8'h02; hb[5] = 8'hCA; hb[6] = 8'h6F;
        f = expect_hdr();
        tick(); i_Sync = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(hb[i], 0, 1'b0);
        @(negedge i_Clk);
        check("t1_pulse", {o_HdrValid, o_Found}, 2'b11);
        @(negedge i_Clk);
        check("t1_busy_drop", o_Busy, 0);
        check("t1_hdr_n", o_HdrN, 8'h02);
        check("t1_crc_errs", o_CrcErrs, 0);
        i_Sync = 1'b0;
        repeat (2) tick();

        // 2: non-matching header then matching one
        do_start(8'h00, 1'b0, 8'h01);
        rearm_cnt = 0;
        make_hdr(8'h00, 8'h00, 8'h03, 8'h02); f = expect_hdr(); send_hdr(7, 2, 1'b0);
        make_hdr(8'h00, 8'h00, 8'h01, 8'h02); f = expect_hdr(); send_hdr(7, 2, 1'b0);
        check("t2_rearm_pulses", rearm_cnt, 1);
        check("t2_hdr_r", o_HdrR, 8'h01);
        check("t2_idle", o_Busy, 0);

        // 3: bad CRC, then saturation
        do_start(8'h00, 1'b0, 8'h01);
        rearm_cnt = 0;
        hb[0] = 8'hFE; hb[1] = 8'h00; hb[2] = 8'h00; hb[3] = 8'h01;
        hb[4] = 8'h02; hb[5] = 8'hCA; hb[6] = 8'h6E;
        f = expect_hdr(); send_hdr(7, 0, 1'b0);
        check("t3_crc_errs_1", o_CrcErrs, 1);
        check("t3_rearm_1", rearm_cnt, 1);
        for (int i = 0; i < 299; i++) begin f = expect_hdr(); send_hdr(7, 0, 1'b0); end
        check("t3_crc_sat", o_CrcErrs, {32'd0, 8'(crc_model)});
        check("t3_crc_sat_ff", o_CrcErrs, 8'hFF);
        make_hdr(8'h00, 8'h00, 8'h01, 8'h02); f = expect_hdr(); send_hdr(7, 1, 1'b0);
        check("t3_idle", o_Busy, 0);

        // 4: wrong address mark
        do_start(8'h00, 1'b0, 8'h01);
        check("t4_errs_cleared", o_CrcErrs, 0);
        rearm_cnt = 0;
        hb[0] = 8'hFB; send_hdr(1, 0, 1'b0);
        check("t4_rearm", rearm_cnt, 1);
        check("t4_hunting", {o_Busy, o_SyncRearm, o_DbgState}, {1'b1, 1'b0, 3'd1});
        make_hdr(8'h00, 8'h00, 8'h01, 8'h02); f = expect_hdr(); send_hdr(7, 1, 1'b0);

        // 5: index limit, alone and against a same-cycle match
        do_start(8'h10, 1'b1, 8'h05);
        idx_edge();
        check("t5_busy_after_1", o_Busy, 1);
        exp_q.push_back({3'b010, 32'h0});
        tick(); i_Index = 1'b1;
        @(negedge i_Clk);
        check("t5_notfound", o_NotFound, 1);
        tick();
        check("t5_busy_drop", o_Busy, 0);
        i_Index = 1'b0; repeat (2) tick();
        do_start(8'h10, 1'b1, 8'h05);
        idx_edge();
        exp_q.push_back({3'b010, 32'h0});
        make_hdr(8'h10, 8'h01, 8'h05, 8'h03);
        send_hdr(7, 1, 1'b1);
        check("t5_coincident_idle", o_Busy, 0);

        // 6: async reset mid-FIELDS, latched target unaffected by busy starts
        do_start(8'h00, 1'b0, 8'h01);
        tick(); i_Sync = 1'b1;
        send_byte(8'hFE, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        #2 i_Reset = 1'b1;
        #1 check("t6_async_reset", {o_SyncRearm, o_Busy}, 2'b10);
        @(negedge i_Clk); i_Reset = 1'b0; i_Sync = 1'b0;
        do_start(8'h05, 1'b1, 8'h07);
        tick(); i_Track = 8'h09; i_Head = 1'b0; i_Sector = 8'h09; i_Start = 1'b1;
        tick(); i_Start = 1'b0;
        make_hdr(8'h09, 8'h00, 8'h09, 8'h01); f = expect_hdr(); send_hdr(7, 1, 1'b0);
        check("t6_still_busy", o_Busy, 1);
        make_hdr(8'h05, 8'h01, 8'h07, 8'h01); f = expect_hdr(); send_hdr(7, 1, 1'b0);
        check("t6_found_idle", o_Busy, 0);

        // randomized searches
        for (int s = 0; s < 15; s++) begin
            logic done;
            int   kind, pos;
            do_start(8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)));
            done = 1'b0;
            for (int h = 0; h < 6 && !done; h++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    hb[0] = 8'($urandom_range(0, 253));
                    send_hdr(1, 0, 1'b0);
                end else begin
                    if ($urandom_range(0, 2) == 0)
                        make_hdr(tgt_c, {7'b0, tgt_h}, tgt_r, 8'($urandom));
                    else
                        make_hdr(8'($urandom_range(0, 3)), 8'($urandom_range(0, 2)),
                                 8'($urandom_range(1, 3)), 8'($urandom));
                    if (kind <= 3) begin
                        pos = $urandom_range(1, 6);
                        hb[pos] = hb[pos] ^ 8'($urandom_range(1, 255));
                    end
                    done = expect_hdr();
                    send_hdr(7, 3, 1'b0);
                end
            end
            if (!done) begin
                make_hdr(tgt_c, {7'b0, tgt_h}, tgt_r, 8'($urandom));
                f = expect_hdr();
                send_hdr(7, 3, 1'b0);
            end
            wait_idle("rand_timeout");
            check("rand_crc_errs", o_CrcErrs, {32'd0, 8'(crc_model)});
        end

        // drain
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        check("drain_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
